// File: rtl/pit_lookup_engine_if.sv
// Request/response channels of the PIT lookup engine: SPI interests, FIB data, responses.
// The master side issues requests and accepts responses. The slave side is the engine.
interface pit_lookup_engine_if #(
  parameter int PREFIX_W = 64,
  parameter int LEN_W    = 6,
  parameter int META_W   = 8,
  parameter int ADDR_W   = 10
);
  logic                int_valid;
  logic                int_ready;
  logic [PREFIX_W-1:0] int_prefix;
  logic [LEN_W-1:0]    int_length;

  logic                dat_valid;
  logic                dat_ready;
  logic [PREFIX_W-1:0] dat_prefix;
  logic [META_W-1:0]   dat_meta;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [ADDR_W:0]     rsp_entry;
  logic [META_W-1:0]   rsp_meta;
  logic                rsp_new;
  logic                rsp_rejected;
  logic                rsp_interest;

  modport master (
    output int_valid, int_prefix, int_length,
    output dat_valid, dat_prefix, dat_meta,
    output rsp_ready,
    input  int_ready, dat_ready,
    input  rsp_valid, rsp_entry, rsp_meta, rsp_new, rsp_rejected, rsp_interest
  );

  modport slave (
    input  int_valid, int_prefix, int_length,
    input  dat_valid, dat_prefix, dat_meta,
    input  rsp_ready,
    output int_ready, dat_ready,
    output rsp_valid, rsp_entry, rsp_meta, rsp_new, rsp_rejected, rsp_interest
  );
endinterface

// File: rtl/pit_lookup_engine.sv
// Pending Interest Table: hashed, linearly probed, tag-checked lookup with one response per request.
// Optional entry ageing and expiry is enabled by defining PIT_TIMEOUT_EN.
module pit_lookup_engine #(
  parameter int PREFIX_W   = 64,
  parameter int LEN_W      = 6,
  parameter int META_W     = 8,
  parameter int IDX_W      = 6,
  parameter int ADDR_W     = 10,
  parameter int BLOCK_SIZE = 1,
`ifdef PIT_TIMEOUT_EN
  parameter int AGE_W      = 4,
  parameter int TICK_DIV   = 1024,
`endif
  parameter int PROBE_MAX  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pit_lookup_engine_if.slave   bus,
  output logic [IDX_W:0]       table_count
);
  localparam int DEPTH   = 1 << IDX_W;
  localparam int NSLICE  = (PREFIX_W + IDX_W - 1) / IDX_W;
  localparam int PCNT_W  = $clog2(PROBE_MAX + 1);
  localparam logic [PCNT_W-1:0] PROBE_LAST = PCNT_W'(PROBE_MAX - 1);

  typedef enum logic [2:0] {IDLE, HASH, PROBE, UPDATE, RESP} state_t;

  state_t state, state_d;

  logic                valid [DEPTH];
  logic                seen  [DEPTH];
  logic [PREFIX_W-1:0] tag   [DEPTH];
  logic [ADDR_W-1:0]   addr  [DEPTH];

  logic                req_is_dat;
  logic [PREFIX_W-1:0] req_prefix;
  logic [LEN_W-1:0]    req_length;
  logic [META_W-1:0]   req_meta;
  logic [IDX_W-1:0]    idx_q, hit_slot, free_slot, probe_slot, wr_slot;
  logic [PCNT_W-1:0]   probe_cnt;
  logic                found, free_found, probe_hit;
  logic [ADDR_W-1:0]   next_addr;
  logic                dat_acc, int_acc, wr_en, wr_alloc, rejected;
  logic [META_W-1:0]   int_meta;

  logic                rsp_valid_q, rsp_new_q, rsp_rejected_q, rsp_interest_q;
  logic [ADDR_W:0]     rsp_entry_q;
  logic [META_W-1:0]   rsp_meta_q;

  function automatic logic [IDX_W-1:0] hash_idx(input logic [PREFIX_W-1:0] p);
    logic [NSLICE*IDX_W-1:0] padded;
    logic [IDX_W-1:0]        h;
    padded = '0;
    padded[PREFIX_W-1:0] = p;
    h = '0;
    for (int s = 0; s < NSLICE; s++) h ^= padded[s*IDX_W +: IDX_W];
    return h;
  endfunction

  assign bus.dat_ready    = (state == IDLE);
  assign bus.int_ready    = (state == IDLE) && !bus.dat_valid;
  assign dat_acc          = bus.dat_valid && bus.dat_ready;
  assign int_acc          = bus.int_valid && bus.int_ready;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_entry    = rsp_entry_q;
  assign bus.rsp_meta     = rsp_meta_q;
  assign bus.rsp_new      = rsp_new_q;
  assign bus.rsp_rejected = rsp_rejected_q;
  assign bus.rsp_interest = rsp_interest_q;

  assign probe_slot = idx_q + IDX_W'(probe_cnt);
  assign probe_hit  = (state == PROBE) && valid[probe_slot] && (tag[probe_slot] == req_prefix);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (dat_acc || int_acc) state_d = HASH;
      HASH:    state_d = PROBE;
      PROBE:   if (probe_hit || probe_cnt == PROBE_LAST) state_d = UPDATE;
      UPDATE:  state_d = RESP;
      RESP:    if (rsp_valid_q && bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en    = 1'b0;
    wr_alloc = 1'b0;
    wr_slot  = hit_slot;
    rejected = 1'b0;
    if (found) begin
      wr_en = (state == UPDATE);
    end else if (!req_is_dat && free_found) begin
      wr_en    = (state == UPDATE);
      wr_alloc = (state == UPDATE);
      wr_slot  = free_slot;
    end else begin
      rejected = 1'b1;
    end
  end

  always_comb begin
    int_meta             = '0;
    int_meta[LEN_W-1:0]  = req_length;
    int_meta[META_W-2]   = 1'b1;
  end

  always_comb begin
    table_count = '0;
    for (int i = 0; i < DEPTH; i++) table_count = table_count + (IDX_W+1)'(valid[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_is_dat     <= 1'b0;
      req_prefix     <= '0;
      req_length     <= '0;
      req_meta       <= '0;
      idx_q          <= '0;
      hit_slot       <= '0;
      free_slot      <= '0;
      probe_cnt      <= '0;
      found          <= 1'b0;
      free_found     <= 1'b0;
      next_addr      <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_entry_q    <= '0;
      rsp_meta_q     <= '0;
      rsp_new_q      <= 1'b0;
      rsp_rejected_q <= 1'b0;
      rsp_interest_q <= 1'b0;
    end else begin
      // Response fields settle in UPDATE; valid follows one cycle into RESP.
      rsp_valid_q <= (state == RESP) && !(rsp_valid_q && bus.rsp_ready);
      unique case (state)
        IDLE: begin
          found      <= 1'b0;
          free_found <= 1'b0;
          probe_cnt  <= '0;
          if (dat_acc) begin
            req_is_dat <= 1'b1;
            req_prefix <= bus.dat_prefix;
            req_meta   <= bus.dat_meta;
          end else if (int_acc) begin
            req_is_dat <= 1'b0;
            req_prefix <= bus.int_prefix;
            req_length <= bus.int_length;
          end
        end
        HASH: idx_q <= hash_idx(req_prefix);
        PROBE: begin
          if (probe_hit) begin
            found    <= 1'b1;
            hit_slot <= probe_slot;
          end else if (!valid[probe_slot] && !free_found) begin
            free_found <= 1'b1;
            free_slot  <= probe_slot;
          end
          probe_cnt <= probe_cnt + 1'b1;
        end
        UPDATE: begin
          rsp_new_q      <= wr_alloc;
          rsp_rejected_q <= rejected;
          rsp_interest_q <= req_is_dat && found && req_meta[6] && seen[hit_slot];
          rsp_meta_q     <= req_is_dat ? req_meta : int_meta;
          if (rejected)      rsp_entry_q <= '0;
          else if (wr_alloc) rsp_entry_q <= {1'b0, next_addr};
          else               rsp_entry_q <= {seen[hit_slot] | req_is_dat, addr[hit_slot]};
          if (wr_alloc) next_addr <= next_addr + ADDR_W'(BLOCK_SIZE);
        end
        default: ;
      endcase
    end
  end

  // NOTE: only the valid bits need reset; tag/addr/seen are always rewritten before becoming visible.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_alloc) begin
        tag[wr_slot]  <= req_prefix;
        addr[wr_slot] <= next_addr;
        seen[wr_slot] <= 1'b0;
      end else if (req_is_dat) begin
        seen[wr_slot] <= 1'b1;
      end
    end
  end

`ifdef PIT_TIMEOUT_EN
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'((1 << AGE_W) - 2);

  logic [DIV_W-1:0] div_cnt;
  logic [AGE_W-1:0] age [DEPTH];
  logic             tick;

  assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_cnt <= '0;
    else      div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid[i] <= 1'b0;
        age[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && wr_slot == IDX_W'(i)) begin
          valid[i] <= 1'b1;
          age[i]   <= '0;
        end else if (tick && valid[i]) begin
          // The tick that would bring the age to its maximum expires the entry instead.
          if (age[i] == AGE_LIMIT) begin
            valid[i] <= 1'b0;
            age[i]   <= '0;
          end else begin
            age[i] <= age[i] + 1'b1;
          end
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) valid[i] <= 1'b0;
    end else if (wr_en) begin
      valid[wr_slot] <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_pit_lookup_engine.sv
// Directed scoreboard bench for pit_lookup_engine: allocation, hits, data flags, rejects,
// collisions, probe wrap, back-pressure, mid-lookup reset and (PIT_TIMEOUT_EN) expiry.
module tb_pit_lookup_engine;
  localparam int PREFIX_W = 64;
  localparam int LEN_W    = 6;
  localparam int META_W   = 8;
  localparam int IDX_W    = 6;
  localparam int ADDR_W   = 10;
  localparam int TICK_DIV = 1024;

  typedef struct {
    logic [ADDR_W:0]   entry;
    logic [META_W-1:0] meta;
    logic              is_new;
    logic              rejected;
    logic              interest;
    int                lat;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [IDX_W:0] table_count;
  exp_t           sb[$];
  int             n_tests = 0;
  int             n_fail  = 0;

  pit_lookup_engine_if #(.PREFIX_W(PREFIX_W), .LEN_W(LEN_W), .META_W(META_W), .ADDR_W(ADDR_W)) bus ();

  pit_lookup_engine #(
    .PREFIX_W(PREFIX_W), .LEN_W(LEN_W), .META_W(META_W), .IDX_W(IDX_W), .ADDR_W(ADDR_W),
    .BLOCK_SIZE(1),
`ifdef PIT_TIMEOUT_EN
    .AGE_W(4), .TICK_DIV(TICK_DIV),
`endif
    .PROBE_MAX(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .table_count(table_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_rsp(input logic [ADDR_W:0] entry, input logic [META_W-1:0] meta,
                            input logic is_new, input logic rej, input logic intr, input int lat);
    exp_t e;
    e.entry = entry; e.meta = meta; e.is_new = is_new;
    e.rejected = rej; e.interest = intr; e.lat = lat;
    sb.push_back(e);
  endtask

  // Drives one request and returns #1 after its accept edge.
  task automatic send(input bit is_dat, input logic [PREFIX_W-1:0] prefix, input logic [7:0] lm);
    int guard = 0;
    @(negedge clk);
    if (is_dat) begin
      bus.dat_valid = 1'b1; bus.dat_prefix = prefix; bus.dat_meta = lm;
    end else begin
      bus.int_valid = 1'b1; bus.int_prefix = prefix; bus.int_length = lm[LEN_W-1:0];
    end
    #1;
    while (!(is_dat ? bus.dat_ready : bus.int_ready) && guard < 100) begin
      @(negedge clk); #1; guard++;
    end
    if (guard >= 100) check("accept_timeout", 64'(guard), 0);
    @(posedge clk); #1;
    bus.dat_valid = 1'b0;
    bus.int_valid = 1'b0;
  endtask

  // Waits for the response, compares it with the scoreboard head, optionally holds rsp_ready low.
  task automatic wait_rsp(input string name, input int hold);
    exp_t e;
    int   cycles = 0;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 64'(sb.size()), 1);
      return;
    end
    e = sb.pop_front();
    while (!bus.rsp_valid && cycles < 64) begin
      @(posedge clk); #1; cycles++;
    end
    check({name, "_latency"},  64'(cycles),       64'(e.lat));
    check({name, "_entry"},    bus.rsp_entry,     e.entry);
    check({name, "_meta"},     bus.rsp_meta,      e.meta);
    check({name, "_new"},      bus.rsp_new,       e.is_new);
    check({name, "_rejected"}, bus.rsp_rejected,  e.rejected);
    check({name, "_interest"}, bus.rsp_interest,  e.interest);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s_hold%0d_valid", name, i), bus.rsp_valid, 1);
      check($sformatf("%s_hold%0d_entry", name, i), bus.rsp_entry, e.entry);
      check($sformatf("%s_hold%0d_ready", name, i), {bus.int_ready, bus.dat_ready}, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check({name, "_valid_drop"}, bus.rsp_valid, 0);
  endtask

  initial begin
    bus.int_valid = 1'b0; bus.int_prefix = '0; bus.int_length = '0;
    bus.dat_valid = 1'b0; bus.dat_prefix = '0; bus.dat_meta   = '0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_readies",   {bus.int_ready, bus.dat_ready}, 2'b11);
    check("rst_count",     table_count, 0);
    check("rst_rsp_bits",  {bus.rsp_entry, bus.rsp_meta, bus.rsp_new, bus.rsp_rejected, bus.rsp_interest}, 0);
    rst = 1'b1;

    // Fresh allocation probes the full window; a hit ends after one slot.
    expect_rsp(11'h000, 8'h45, 1, 0, 0, 7); send(0, 64'h1, 8'd5); wait_rsp("t1_alloc", 0);
    check("t1_count", table_count, 1);
    expect_rsp(11'h000, 8'h45, 0, 0, 0, 4); send(0, 64'h1, 8'd5); wait_rsp("t2_hit", 0);
    expect_rsp(11'h001, 8'h43, 1, 0, 0, 7); send(0, 64'h2, 8'd3); wait_rsp("t2_alloc2", 0);
    check("t2_count", table_count, 2);

    expect_rsp(11'h400, 8'h40, 0, 0, 0, 4); send(1, 64'h1, 8'h40); wait_rsp("t3_dat1", 0);
    expect_rsp(11'h400, 8'h40, 0, 0, 1, 4); send(1, 64'h1, 8'h40); wait_rsp("t3_dat2", 0);

    expect_rsp(11'h000, 8'h11, 0, 1, 0, 7); send(1, 64'hDEAD, 8'h11); wait_rsp("t4_dat_miss", 0);
    check("t4_count", table_count, 2);

    // Simultaneous requests: FIB first, interest waits.
    expect_rsp(11'h401, 8'h55, 0, 0, 0, 4);
    expect_rsp(11'h002, 8'h41, 1, 0, 0, 7);
    @(negedge clk);
    bus.dat_valid = 1'b1; bus.dat_prefix = 64'h2; bus.dat_meta = 8'h55;
    bus.int_valid = 1'b1; bus.int_prefix = 64'h3; bus.int_length = 6'd1;
    #1;
    check("t4_dual_int_ready", bus.int_ready, 0);
    @(posedge clk); #1;
    bus.dat_valid = 1'b0;
    wait_rsp("t4_dual_dat", 0);
    @(posedge clk); #1;
    bus.int_valid = 1'b0;
    wait_rsp("t4_dual_int", 0);
    check("t4_dual_count", table_count, 3);

    // Prefixes (a<<6)|(a^40) all hash to slot 40.
    for (int a = 0; a < 4; a++) begin
      expect_rsp(11'(3 + a), 8'h42, 1, 0, 0, 7);
      send(0, 64'((a << 6) | (a ^ 40)), 8'd2);
      wait_rsp($sformatf("t5_coll%0d", a), 0);
    end
    expect_rsp(11'h000, 8'h42, 0, 1, 0, 7); send(0, 64'((4 << 6) | (4 ^ 40)), 8'd2); wait_rsp("t5_coll4_rej", 0);
    check("t5_count", table_count, 7);
    expect_rsp(11'h004, 8'h42, 0, 0, 0, 5); send(0, 64'((1 << 6) | (1 ^ 40)), 8'd2); wait_rsp("t5_coll1_hit", 0);

    // Index 63: window 63,0,1,2 wraps onto slots 0..2.
    expect_rsp(11'h007, 8'h42, 1, 0, 0, 7); send(0, 64'h3F, 8'd2); wait_rsp("t5_wrap0", 0);
    expect_rsp(11'h008, 8'h42, 1, 0, 0, 7); send(0, 64'h7E, 8'd2); wait_rsp("t5_wrap1", 0);
    expect_rsp(11'h000, 8'h42, 0, 1, 0, 7); send(0, 64'hBD, 8'd2); wait_rsp("t5_wrap2_rej", 0);
    expect_rsp(11'h008, 8'h42, 0, 0, 0, 5); send(0, 64'h7E, 8'd2); wait_rsp("t5_wrap1_hit", 0);
    check("t5_wrap_count", table_count, 9);

    bus.rsp_ready = 1'b0;
    expect_rsp(11'h002, 8'h41, 0, 0, 0, 4); send(0, 64'h3, 8'd1); wait_rsp("t6_hold", 10);

    // Reset while the engine is probing.
    send(0, 64'h1234, 8'd7);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("t6_rst_rsp_valid", bus.rsp_valid, 0);
    check("t6_rst_readies",   {bus.int_ready, bus.dat_ready}, 2'b11);
    check("t6_rst_count",     table_count, 0);
    @(negedge clk);
    rst = 1'b1;
    expect_rsp(11'h000, 8'h45, 1, 0, 0, 7); send(0, 64'h1, 8'd5); wait_rsp("t6_realloc", 0);
    check("t6_realloc_count", table_count, 1);

`ifdef PIT_TIMEOUT_EN
    repeat (16 * TICK_DIV) @(posedge clk);
    #1;
    check("t6_expired_count", table_count, 0);
`endif

    check("sb_drained", 64'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
